// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon round controller.
package simon_pkg;

  localparam int unsigned COLOR_W = 2;
  localparam int unsigned LED_W   = 4;
  localparam int unsigned TMR_W   = 25;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PLAY_ON,
    ST_PLAY_OFF,
    ST_IN_WAIT,
    ST_IN_ECHO,
    ST_PASS,
    ST_FAIL
  } state_t;

  function automatic logic [LED_W-1:0] onehot(input logic [COLOR_W-1:0] c);
    return 4'b0001 << c;
  endfunction

endpackage

// File: rtl/simon_round_ctrl.sv
// Sequences one Simon round: pattern playback on the LEDs, then timed
// checking of player presses, using the shared countdown timer.
module simon_round_ctrl
  import simon_pkg::*;
#(
  parameter logic [TMR_W-1:0] ON_TICKS      = 25'd12_500_000,
  parameter logic [TMR_W-1:0] OFF_TICKS     = 25'd6_250_000,
  parameter logic [TMR_W-1:0] TIMEOUT_TICKS = 25'd25_000_000,
  parameter int unsigned      ADDR_W        = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  round_len,
  output logic [ADDR_W-1:0]  seq_addr,
  input  logic [COLOR_W-1:0] seq_color,
  input  logic [LED_W-1:0]   btn,
  output logic [LED_W-1:0]   led,
  output logic [TMR_W-1:0]   tmr_load,
  output logic               tmr_reset,
  output logic               tmr_enable,
  input  logic               tmr_pulse,
  output logic               busy,
  output logic               round_pass,
  output logic               round_fail
);

  state_t               state, state_d;
  logic [ADDR_W-1:0]    idx, idx_d;
  logic [ADDR_W-1:0]    len, len_d;
  logic [COLOR_W-1:0]   color, color_d;
  logic                 last_step;
  logic                 expired;
  logic                 timed_d;
  logic [TMR_W-1:0]     load_d;
  logic [LED_W-1:0]     led_d;

  assign seq_addr = idx;

  always_comb begin
    state_d   = state;
    idx_d     = idx;
    len_d     = len;
    color_d   = color;
    last_step = (idx == len - ADDR_W'(1));
    // The registered arm strobe marks the first cycle of a timed state,
    // where a stale expiry from the previous interval must be ignored.
    expired   = tmr_pulse && !tmr_reset;

    unique case (state)
      ST_IDLE: begin
        if (start && (round_len != '0)) begin
          len_d   = round_len;
          idx_d   = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        color_d = seq_color;
        state_d = ST_PLAY_ON;
      end
      ST_PLAY_ON: begin
        if (expired) state_d = ST_PLAY_OFF;
      end
      ST_PLAY_OFF: begin
        if (expired) begin
          if (last_step) begin
            idx_d   = '0;
            state_d = ST_IN_WAIT;
          end else begin
            idx_d   = idx + ADDR_W'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_IN_WAIT: begin
        if (btn != '0) begin
          if (btn == onehot(seq_color)) begin
            color_d = seq_color;
            state_d = ST_IN_ECHO;
          end else begin
            state_d = ST_FAIL;
          end
        end else if (expired) begin
          state_d = ST_FAIL;
        end
      end
      ST_IN_ECHO: begin
        if (expired) begin
          if (last_step) begin
            state_d = ST_PASS;
          end else begin
            idx_d   = idx + ADDR_W'(1);
            state_d = ST_IN_WAIT;
          end
        end
      end
      ST_PASS: state_d = ST_IDLE;
      ST_FAIL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    timed_d = 1'b0;
    load_d  = '0;
    led_d   = '0;
    unique case (state_d)
      ST_PLAY_ON: begin
        timed_d = 1'b1;
        load_d  = ON_TICKS;
        led_d   = onehot(color_d);
      end
      ST_PLAY_OFF: begin
        timed_d = 1'b1;
        load_d  = OFF_TICKS;
      end
      ST_IN_WAIT: begin
        timed_d = 1'b1;
        load_d  = TIMEOUT_TICKS;
      end
      ST_IN_ECHO: begin
        timed_d = 1'b1;
        load_d  = OFF_TICKS;
        led_d   = onehot(color_d);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      len        <= '0;
      color      <= '0;
      led        <= '0;
      tmr_load   <= '0;
      tmr_reset  <= 1'b0;
      tmr_enable <= 1'b0;
      busy       <= 1'b0;
      round_pass <= 1'b0;
      round_fail <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      len        <= len_d;
      color      <= color_d;
      led        <= led_d;
      tmr_load   <= load_d;
      tmr_reset  <= timed_d && (state_d != state);
      tmr_enable <= timed_d;
      busy       <= (state_d != ST_IDLE);
      round_pass <= (state_d == ST_PASS);
      round_fail <= (state_d == ST_FAIL);
    end
  end

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Scoreboard bench for simon_round_ctrl with a behavioural countdown-timer model.
module tb_simon_round_ctrl;
  import simon_pkg::*;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned ON  = 4;
  localparam int unsigned OFF = 2;
  localparam int unsigned TMO = 10;

  localparam int unsigned EV_ARM  = 0;
  localparam int unsigned EV_PASS = 1;
  localparam int unsigned EV_FAIL = 2;

  localparam int unsigned A_OK    = 0;
  localparam int unsigned A_WRONG = 1;
  localparam int unsigned A_TMO   = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] round_len = '0;
  logic [ADDR_W-1:0] seq_addr;
  logic [1:0]        seq_color;
  logic [3:0]        btn = '0;
  logic [3:0]        led;
  logic [24:0]       tmr_load;
  logic              tmr_reset;
  logic              tmr_enable;
  logic              tmr_pulse = 1'b0;
  logic              busy;
  logic              round_pass;
  logic              round_fail;

  logic [1:0] pat [32];
  assign seq_color = pat[seq_addr];

  simon_round_ctrl #(
    .ON_TICKS     (25'(ON)),
    .OFF_TICKS    (25'(OFF)),
    .TIMEOUT_TICKS(25'(TMO)),
    .ADDR_W       (ADDR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .round_len (round_len),
    .seq_addr  (seq_addr),
    .seq_color (seq_color),
    .btn       (btn),
    .led       (led),
    .tmr_load  (tmr_load),
    .tmr_reset (tmr_reset),
    .tmr_enable(tmr_enable),
    .tmr_pulse (tmr_pulse),
    .busy      (busy),
    .round_pass(round_pass),
    .round_fail(round_fail)
  );

  always #5 clk = ~clk;

  // Timer: expiry is high exactly L cycles after the arm cycle.
  int unsigned tcnt = 0;
  bit          tact = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      tact      <= 1'b0;
      tcnt      <= 0;
      tmr_pulse <= 1'b0;
    end else if (tmr_reset) begin
      tact      <= 1'b1;
      tcnt      <= int'(tmr_load) - 1;
      tmr_pulse <= 1'b0;
    end else if (tact && tmr_enable) begin
      tmr_pulse <= (tcnt == 0);
      tact      <= (tcnt != 0);
      tcnt      <= tcnt - 1;
    end else begin
      tmr_pulse <= 1'b0;
      tact      <= 1'b0;
    end
  end

  typedef struct {
    int unsigned kind;
    logic [24:0] load;
    logic [3:0]  led;
    logic [4:0]  addr;
    int unsigned gap;
  } ev_t;

  ev_t expq[$];
  int  checks = 0;
  int  errors = 0;

  int unsigned act  [32];
  int unsigned dly  [32];
  logic [3:0]  wbtn [32];

  function automatic logic [3:0] color_led(input logic [1:0] c);
    logic [3:0] one;
    one = 4'd1;
    return one << c;
  endfunction

  function automatic void push_ev(input int unsigned kind, input int unsigned load,
                                  input logic [3:0] l, input int unsigned addr,
                                  input int unsigned gap);
    ev_t e;
    e.kind = kind;
    e.load = 25'(load);
    e.led  = l;
    e.addr = 5'(addr);
    e.gap  = gap;
    expq.push_back(e);
  endfunction

  // Reference: each timed interval of L lasts L+1 cycles (arm cycle plus L),
  // FETCH adds one cycle; gaps are cycles between observable events.
  function automatic void model_round(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      push_ev(EV_ARM, ON, color_led(pat[i]), i, (i == 0) ? 1 : OFF + 2);
      push_ev(EV_ARM, OFF, 4'b0000, i, ON + 1);
    end
    for (int unsigned i = 0; i < n; i++) begin
      push_ev(EV_ARM, TMO, 4'b0000, i, OFF + 1);
      if (act[i] == A_OK) begin
        push_ev(EV_ARM, OFF, color_led(pat[i]), i, dly[i] + 1);
        if (i == n - 1) push_ev(EV_PASS, 0, 4'b0000, i, OFF + 1);
      end else if (act[i] == A_WRONG) begin
        push_ev(EV_FAIL, 0, 4'b0000, i, dly[i] + 1);
        break;
      end else begin
        push_ev(EV_FAIL, 0, 4'b0000, i, TMO + 1);
        break;
      end
    end
  endfunction

  task automatic check(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: every arm strobe or result pulse is matched against the queue.
  int unsigned mgap  = 0;
  bit          mprev = 1'b0;
  initial begin
    ev_t         e;
    int unsigned kind;
    bit          bad;
    forever begin
      @(negedge clk);
      if (!reset) begin
        mprev = 1'b0;
        mgap  = 0;
      end else begin
        if (busy && !mprev) mgap = 0;
        else mgap++;
        if (tmr_reset || round_pass || round_fail) begin
          kind = tmr_reset ? EV_ARM : (round_pass ? EV_PASS : EV_FAIL);
          checks++;
          if (expq.size() == 0) begin
            errors++;
            $display("FAIL event: got kind=%0d load=%0d led=%b addr=%0d gap=%0d, expected no event",
                     kind, tmr_load, led, seq_addr, mgap);
          end else begin
            e = expq.pop_front();
            bad = (kind != e.kind) || (led !== e.led) || (seq_addr !== e.addr) ||
                  (mgap != e.gap) || (tmr_enable !== (e.kind == EV_ARM)) ||
                  ((e.kind == EV_ARM) && (tmr_load !== e.load));
            if (bad) begin
              errors++;
              $display("FAIL event: got kind=%0d load=%0d led=%b addr=%0d gap=%0d en=%b, expected kind=%0d load=%0d led=%b addr=%0d gap=%0d",
                       kind, tmr_load, led, seq_addr, mgap, tmr_enable,
                       e.kind, e.load, e.led, e.addr, e.gap);
            end
          end
          mgap = 0;
        end
        mprev = busy;
      end
    end
  end

  task automatic wait_arm(input int unsigned load, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (tmr_reset && (tmr_load == 25'(load))) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_arm: no arm with load %0d within 600 cycles", load);
    end
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (!busy) begin
        idle = 1'b1;
        break;
      end
    end
    check("busy_drops", longint'(idle), 1);
    check("queue_drained", longint'(expq.size()), 0);
  endtask

  task automatic run_round(input int unsigned n, input bit glitch);
    bit ok;
    model_round(n);
    round_len = ADDR_W'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    round_len = ADDR_W'($urandom);
    if (glitch) begin
      wait_arm(OFF, ok);
      if (ok) begin
        start = 1'b1;
        round_len = 5'd7;
        @(negedge clk);
        start = 1'b0;
      end
    end
    for (int unsigned i = 0; i < n; i++) begin
      wait_arm(TMO, ok);
      if (!ok) break;
      if (act[i] != A_TMO) begin
        repeat (dly[i]) @(negedge clk);
        btn = (act[i] == A_OK) ? color_led(pat[i]) : wbtn[i];
        @(negedge clk);
        btn = '0;
      end
      if (act[i] != A_OK) break;
    end
    wait_idle();
  endtask

  task automatic set_all_ok(input int unsigned d);
    for (int i = 0; i < 32; i++) begin
      act[i] = A_OK;
      dly[i] = d;
      wbtn[i] = '0;
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, longint'({led, tmr_load, tmr_reset, tmr_enable, busy,
                          round_pass, round_fail, seq_addr}), 0);
  endtask

  initial begin
    bit          ok;
    int unsigned n;
    int unsigned r;
    logic [3:0]  b;
    bit          quiet;

    for (int i = 0; i < 32; i++) pat[i] = 2'(i);
    set_all_ok(3);
    #12;
    check_outputs_zero("reset_state");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Directed pattern {2,0,3}, correct presses 3 cycles after each arm,
    // with an ignored start during playback.
    pat[0] = 2'd2; pat[1] = 2'd0; pat[2] = 2'd3;
    set_all_ok(3);
    run_round(3, 1'b1);

    // Wrong single-bit press at step 1.
    set_all_ok(3);
    act[1] = A_WRONG; wbtn[1] = 4'b0010;
    run_round(3, 1'b0);

    // Two-bit press at step 0.
    set_all_ok(3);
    act[0] = A_WRONG; dly[0] = 1; wbtn[0] = 4'b0101;
    run_round(2, 1'b0);

    // Timeout with no press.
    set_all_ok(3);
    act[0] = A_TMO;
    run_round(1, 1'b0);

    // Press coinciding with expiry wins; then a press in the arm cycle.
    set_all_ok(3);
    dly[0] = TMO; dly[1] = 0;
    run_round(2, 1'b0);

    // Zero-length start is ignored.
    round_len = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (busy || tmr_enable) quiet = 1'b0;
    end
    check("len0_stays_idle", longint'(quiet), 1);

    // Maximum-length round.
    for (int i = 0; i < 32; i++) pat[i] = 2'($urandom);
    set_all_ok(0);
    run_round(31, 1'b0);

    // Asynchronous reset during PLAY_ON.
    pat[0] = 2'd1; pat[1] = 2'd2; pat[2] = 2'd3;
    set_all_ok(3);
    model_round(3);
    round_len = 5'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_arm(ON, ok);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_outputs_zero("async_reset_outputs");
    expq.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    quiet = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (round_pass || round_fail || busy) quiet = 1'b0;
    end
    check("post_reset_quiet", longint'(quiet), 1);

    // Randomised rounds.
    for (int k = 0; k < 12; k++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < 32; i++) begin
        pat[i] = 2'($urandom);
        r = $urandom_range(0, 9);
        act[i] = (r < 7) ? A_OK : ((r == 7) ? A_WRONG : A_TMO);
        dly[i] = $urandom_range(0, TMO);
        do b = 4'($urandom_range(1, 15)); while (b == color_led(pat[i]));
        wbtn[i] = b;
      end
      run_round(n, k[0]);
    end

    check("final_queue_empty", longint'(expq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
